sfetch_unit: RTL and testbench
==============================

// Module: sfetch_unit
// PURPOSE
//   Instruction fetch stage upstream of the 5-stage core's IF/ID register. Generates sequential
//   fetch PCs and issues in-order requests to instruction memory over a valid/ready channel.
//   Buffers returned instructions with their PCs in a small prefetch FIFO and presents them to
//   decode over valid/ready. Handles branch/jump redirects by flushing the buffer and discarding
//   stale in-flight responses.
// PARAMETERS
//   ADDR_WIDTH  32            fetch address / PC width
//   DATA_WIDTH  32            instruction width
//   FIFO_DEPTH  4             prefetch entries; power of 2, >=2; also caps in-flight + buffered
//   RESET_PC    32'h0000_0000 first fetch address after reset
// PORTS
//   clk              in   1           core clock; all state on posedge
//   rst              in   1           asynchronous, active-high reset
//   redirect_i       in   1           taken branch/jump resolved; redirect fetch this cycle
//   redirect_pc_i    in   ADDR_WIDTH  new fetch target; bits[1:0] ignored (forced 0)
//   imem_req_valid_o out  1           fetch request valid
//   imem_req_ready_i in   1           imem accepts request
//   imem_req_addr_o  out  ADDR_WIDTH  word-aligned fetch address
//   imem_rsp_valid_i in   1           response valid; in order, one per accepted request, never stalls
//   imem_rsp_data_i  in   DATA_WIDTH  fetched instruction
//   instr_valid_o    out  1           instr_o/pc_o valid to decode
//   instr_ready_i    in   1           decode consumes (low = pipeline stall)
//   instr_o          out  DATA_WIDTH  instruction; NOP (32'h0000_0013) when !instr_valid_o
//   pc_o             out  ADDR_WIDTH  PC of instr_o
// BEHAVIOUR
//   - Reset: fetch_pc=rsp_pc=RESET_PC; FIFO empty; outstanding=drop_cnt=0; state=BOOT;
//     imem_req_valid_o=0, instr_valid_o=0, instr_o=NOP, pc_o=0.
//   - FSM: BOOT -> RUN one cycle after reset deassert. RUN -> DRAIN on redirect with stale
//     responses pending. DRAIN -> RUN when drop_cnt reaches 0. Redirect in DRAIN stays in DRAIN
//     and reloads drop_cnt.
//   - Credit: req_valid = (state!=BOOT) & !redirect_i & (fifo_count + outstanding < FIFO_DEPTH).
//     Once asserted without redirect, req_valid/addr stay stable until accepted.
//   - Accept (valid&ready): fetch_pc+=4 (wraps modulo 2^ADDR_WIDTH); outstanding+=1.
//   - Response: outstanding-=1. drop_cnt>0 -> discard, drop_cnt-=1. Else push {rsp_pc, data};
//     rsp_pc+=4. Credits guarantee FIFO never overflows; full+push is an assertion error.
//   - Output: FIFO head drives instr_o/pc_o combinationally. Pop on valid&ready. Push and pop
//     may occur in the same cycle.
//   - Latency: accepted request with same-cycle response -> instr_valid_o the next cycle.
//     Empty FIFO with a response present does not bypass.
//   - Redirect (priority over all else in that cycle):
//       FIFO flushed, so instr_valid_o=0 next cycle; same-cycle pop ignored.
//       fetch_pc = rsp_pc = {redirect_pc_i[AW-1:2],2'b00}.
//       drop_cnt = outstanding - (rsp_valid this cycle); any same-cycle response is discarded.
//       No request issued in the redirect cycle.
//   - Async rst mid-operation clears everything immediately. The imem channel is reset on the
//     same rst, so no response is expected from pre-reset requests.
// STRUCTURE
//   - Package riscv_pkg: fetch_entry_t {pc, instr}; INSTR_BYTES=4; NOP_INSTR=32'h0000_0013;
//     fetch_state_e {BOOT, RUN, DRAIN}.
//   - Sub-module sfetch_fifo: sync FIFO of fetch_entry_t with push/pop/flush/count.
//     Same-cycle push+pop is legal; flush beats push.
//   - Top level holds the FSM, fetch_pc, rsp_pc, outstanding, drop_cnt and credit logic.
// TESTING
//   1 Reset release, imem ready=1, rsp 1 cycle later, instr_ready=1 -> PCs 0,4,8,12...
//     in order; first instr_valid_o 3 cycles after rst falls.
//   2 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 requests issued, then req_valid=0
//     until the first pop.
//   3 Redirect to 32'h100 with 2 requests outstanding -> both responses dropped; next
//     instr_o at pc_o=32'h100; no PC 0x8/0xC delivered.
//   4 Redirect in the same cycle as a response and a pop -> response discarded, FIFO empty
//     next cycle, drop_cnt = outstanding-1.
//   5 imem_req_ready=0 for 5 cycles -> req_valid/addr held stable; redirect_pc_i=32'h203
//     fetches 32'h200.
//   6 fetch_pc=32'hFFFF_FFFC accepted -> next request address 32'h0; rst pulsed mid-DRAIN ->
//     all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: the prefetch entry layout, the fetch FSM
// states and the architectural NOP presented to decode when nothing is valid.
package riscv_pkg;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sfetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries. Push and pop may coincide;
// flush empties the FIFO and takes priority over a same-cycle push or pop.
module sfetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & ~i_flush & (r_count != '0);

  // Storage carries only data, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // The fetch credit scheme must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && !w_pop && (r_count == CW'(DEPTH))));
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/sfetch_unit.sv
// Instruction fetch stage: credit-limited in-order imem requests, prefetch buffering
// toward decode, and redirect handling that flushes the buffer and drops stale responses.
module sfetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_WIDTH = 32,
  parameter int                DATA_WIDTH = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_rsp_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_drop_cnt;

  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_empty;
  fetch_entry_t          w_fifo_head;
  fetch_entry_t          w_fifo_in;
  logic                  w_credit_ok;
  logic                  w_req_valid;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_stale;
  logic [ADDR_WIDTH-1:0] w_redir_pc;
  logic                  w_unused_pc_lsb;

  assign w_redir_pc      = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  // Buffered plus in-flight entries may never exceed the FIFO capacity.
  assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < (CW+1)'(FIFO_DEPTH);
  assign w_req_valid = (r_state != BOOT) & ~redirect_i & w_credit_ok;
  assign w_accept    = w_req_valid & imem_req_ready_i;

  assign w_drop  = imem_rsp_valid_i & (redirect_i | (r_drop_cnt != '0));
  assign w_push  = imem_rsp_valid_i & ~w_drop;
  assign w_pop   = ~w_fifo_empty & instr_ready_i & ~redirect_i;
  assign w_stale = r_outstanding - CW'(imem_rsp_valid_i);

  assign w_fifo_in.pc    = r_rsp_pc;
  assign w_fifo_in.instr = imem_rsp_data_i;

  sfetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_fifo_in),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_head  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:  w_state_nxt = RUN;
      RUN:   if (redirect_i && (w_stale != '0)) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!redirect_i && ((r_drop_cnt == '0) ||
                            ((r_drop_cnt == CW'(1)) && imem_rsp_valid_i))) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid_i);
      if (redirect_i) begin
        // Everything still in flight belongs to the old path.
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_drop_cnt <= w_stale;
      end else begin
        if (w_accept) begin
          r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + ADDR_WIDTH'(INSTR_BYTES);
        end
      end
    end
  end

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_fetch_pc;
  assign instr_valid_o    = ~w_fifo_empty;
  assign instr_o          = w_fifo_empty ? NOP_INSTR : w_fifo_head.instr;
  assign pc_o             = w_fifo_empty ? '0 : w_fifo_head.pc;

endmodule

// File: tb/tb_sfetch_unit.sv
// Bench for sfetch_unit: an imem model with configurable latency and a queue-based
// reference of buffered and in-flight fetches, driven by directed and random steps.
module tb_sfetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  always #5 clk = ~clk;

  sfetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_o          (instr_o),
    .pc_o             (pc_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
    logic [31:0] due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] del_q[$];
  logic [31:0] exp_req_addr;
  logic        booted;
  logic        prev_held;
  logic [31:0] prev_addr;
  int          cyc_n;
  int          lat;
  int          n_acc;
  int          first_valid_cyc;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_0F17;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    buf_q.delete();
    del_q.delete();
    exp_req_addr    = 32'h0;
    booted          = 1'b0;
    prev_held       = 1'b0;
    prev_addr       = '0;
    cyc_n           = 0;
    first_valid_cyc = -1;
  endtask

  // One clock cycle: drive, check against the reference, then advance the reference.
  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic qr, input logic ir);
    logic  rsp_now;
    logic  exp_rv;
    logic  acc;
    logic  pop;
    pend_t e;
    @(negedge clk);
    redirect_i       = rd;
    redirect_pc_i    = rpc;
    imem_req_ready_i = qr;
    instr_ready_i    = ir;
    rsp_now = (pend_q.size() != 0) && (pend_q[0].due <= 32'(cyc_n));
    imem_rsp_valid_i = rsp_now;
    imem_rsp_data_i  = rsp_now ? imem_word(pend_q[0].addr) : $urandom;
    #1;
    exp_rv = booted && !rd && ((buf_q.size() + pend_q.size()) < 4);
    check("req_valid", imem_req_valid_o, exp_rv);
    if (exp_rv) check("req_addr", imem_req_addr_o, exp_req_addr);
    if (prev_held && !rd) begin
      check("req_hold_valid", imem_req_valid_o, 1);
      check("req_hold_addr", imem_req_addr_o, prev_addr);
    end
    check("instr_valid", instr_valid_o, buf_q.size() != 0);
    if (buf_q.size() != 0) begin
      check("pc_o", pc_o, buf_q[0]);
      check("instr_o", instr_o, imem_word(buf_q[0]));
    end else begin
      check("instr_nop", instr_o, NOP);
      check("pc_zero", pc_o, 32'h0);
    end
    if (instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc_n;
    acc       = exp_rv && qr;
    pop       = (buf_q.size() != 0) && ir && !rd;
    prev_held = exp_rv && !qr;
    prev_addr = exp_req_addr;
    @(posedge clk);
    if (rd) begin
      buf_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_req_addr = {rpc[31:2], 2'b00};
    end else if (pop) begin
      del_q.push_back(buf_q.pop_front());
    end
    if (rsp_now) begin
      e = pend_q.pop_front();
      if (!e.stale) buf_q.push_back(e.addr);
    end
    if (acc) begin
      e.addr  = exp_req_addr;
      e.stale = 1'b0;
      e.due   = 32'(cyc_n + lat);
      pend_q.push_back(e);
      exp_req_addr = exp_req_addr + 32'd4;
      n_acc++;
    end
    booted = 1'b1;
    cyc_n++;
  endtask

  initial begin
    lat   = 1;
    n_acc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", imem_req_valid_o, 0);
    check("rst_instr_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, NOP);
    check("rst_pc", pc_o, 32'h0);
    #1;
    rst = 1'b0;

    // 1: sequential fetch from reset, one-cycle imem latency
    repeat (12) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    check("t1_first_valid_cycle", 32'(first_valid_cyc), 32'd3);
    check("t1_first_pc", (del_q.size() != 0) ? del_q[0] : 32'hDEAD_BEEF, 32'h0);
    check("t1_second_pc", (del_q.size() > 1) ? del_q[1] : 32'hDEAD_BEEF, 32'h4);

    // 2: decode stalled -> exactly FIFO_DEPTH requests
    cyc(1'b1, 32'h40, 1'b1, 1'b1);
    n_acc = 0;
    repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("t2_req_count", 32'(n_acc), 32'd4);
    #1;
    check("t2_req_low", imem_req_valid_o, 0);
    repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b1);

    // 3: redirect with two requests in flight
    lat = 2;
    repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 32'h100, 1'b1, 1'b1);
    del_q.delete();
    repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    check("t3_first_pc", (del_q.size() != 0) ? del_q[0] : 32'hDEAD_BEEF, 32'h100);

    // 4: redirect coinciding with a response and a pop
    lat = 1;
    repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 32'h300, 1'b1, 1'b1);
    #1;
    check("t4_flushed", instr_valid_o, 0);
    repeat (5) cyc(1'b0, 32'h0, 1'b1, 1'b1);

    // 5: imem back-pressure then misaligned redirect target
    repeat (5) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h203, 1'b0, 1'b1);
    #1;
    check("t5_aligned_addr", imem_req_addr_o, 32'h200);
    repeat (5) cyc(1'b0, 32'h0, 1'b1, 1'b1);

    // 6a: fetch address wraps past the top of the address space
    cyc(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    check("t6_wrap_addr", imem_req_addr_o, 32'h0);
    repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b1);

    // 6b: asynchronous reset while draining stale responses
    lat = 3;
    repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b1, 32'h500, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    redirect_i       = 1'b0;
    imem_rsp_valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_req_valid", imem_req_valid_o, 0);
    check("t6_rst_instr_valid", instr_valid_o, 0);
    check("t6_rst_instr", instr_o, NOP);
    check("t6_rst_pc", pc_o, 32'h0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    lat = 1;
    repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b1);
    check("t6_restart_pc", (del_q.size() != 0) ? del_q[0] : 32'hDEAD_BEEF, 32'h0);

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      logic        rd;
      logic [31:0] rpc;
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 3);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : ($urandom & 32'h0000_FFFF);
      cyc(rd, rpc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
